// File: rtl/tff_bist_pkg.sv
// ---------------------------------------------------------------------------
// tff_bist_pkg
// Shared definitions for the T flip-flop BIST generator/checker.
//   bist_state_t : controller states
//   LFSR_TAPS    : feedback taps of x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   FAIL_SAT     : saturation value of the mismatch counter
//   sat_inc      : saturating increment for the mismatch counter
// ---------------------------------------------------------------------------
package tff_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN,
        DONE
    } bist_state_t;

    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
    localparam logic [7:0] FAIL_SAT  = 8'd255;

    // Counter stops at FAIL_SAT instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == FAIL_SAT) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/tff_bist_lfsr.sv
// ---------------------------------------------------------------------------
// tff_bist_lfsr
// Fibonacci LFSR that supplies the pseudo-random stimulus.
// Shifts left, feedback (XOR of tapped bits) enters at bit 0.
// Ports:
//   clk    in   clock
//   clear  in   synchronous active-high reset, reloads SEED
//   load   in   reload SEED (start of a run)
//   en     in   advance one step
//   value  out  current LFSR state
// ---------------------------------------------------------------------------
import tff_bist_pkg::*;

module tff_bist_lfsr #(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] SEED   = 8'hA5
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic              en,
    output logic [LFSR_W-1:0] value
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

    logic feedback;

    assign feedback = ^(value & TAPS);

    // Reset and load both return to SEED so every run replays the same vectors.
    always_ff @(posedge clk) begin
        if (clear || load) begin
            value <= SEED;
        end else if (en) begin
            value <= {value[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/tff_bist_gen.sv
// ---------------------------------------------------------------------------
// tff_bist_gen
// BIST generator and response checker for one T flip-flop under test.
// A run is INIT (clear the DUT), N_PATTERNS random vectors, then DRAIN.
// An internal golden model tracks the expected q and every driven vector
// is checked two cycles after it was driven.
// Ports:
//   clk              in   clock
//   clear            in   synchronous active-high reset
//   start            in   run request, honoured only in IDLE or DONE
//   dut_q            in   q returned by the flip-flop under test
//   t_out            out  registered t stimulus
//   dut_clear        out  registered clear stimulus
//   busy             out  run in progress
//   done             out  run finished, held until next start or clear
//   fault_indicator  out  sticky mismatch flag for the current run
//   fail_count       out  saturating mismatch count
// ---------------------------------------------------------------------------
import tff_bist_pkg::*;

module tff_bist_gen #(
    parameter int                LFSR_W     = 8,
    parameter logic [LFSR_W-1:0] SEED       = 8'hA5,
    parameter int                N_PATTERNS = 200
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       dut_q,
    output logic       t_out,
    output logic       dut_clear,
    output logic       busy,
    output logic       done,
    output logic       fault_indicator,
    output logic [7:0] fail_count
);

    localparam logic [15:0] LAST_PAT = 16'(N_PATTERNS - 1);

    // Values below this limit have their top three bits all zero.
    localparam logic [LFSR_W-1:0] CLR_LIMIT = {3'b001, {(LFSR_W-3){1'b0}}};

    bist_state_t       state;
    bist_state_t       next_state;
    logic [LFSR_W-1:0] lfsr_val;
    logic [15:0]       pat_cnt;
    logic              start_accept;
    logic              lfsr_step;
    logic              t_next;
    logic              clr_next;
    logic              valid_next;
    logic              vec_valid;
    logic              cmp_valid;
    logic              exp_q;

    assign start_accept = ((state == IDLE) || (state == DONE)) && start;

    // The LFSR advances on every edge that latches a RUN vector, so the
    // vector just registered comes from the pre-step value.
    assign lfsr_step = (next_state == RUN);

    assign busy = (state == INIT) || (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    tff_bist_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk    (clk),
        .clear  (clear),
        .load   (start_accept),
        .en     (lfsr_step),
        .value  (lfsr_val)
    );

    // Controller next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = INIT;
            INIT:    next_state = RUN;
            RUN:     if (pat_cnt == LAST_PAT) next_state = DRAIN;
            DRAIN:   next_state = DONE;
            DONE:    if (start) next_state = INIT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Vector for the coming cycle is chosen from the state being entered,
    // which keeps t_out/dut_clear registered yet aligned with the state.
    always_comb begin
        t_next     = 1'b0;
        clr_next   = 1'b0;
        valid_next = 1'b0;
        case (next_state)
            IDLE: begin
                clr_next = 1'b1;
            end
            INIT: begin
                clr_next   = 1'b1;
                valid_next = 1'b1;
            end
            RUN: begin
                t_next     = lfsr_val[0];
                clr_next   = (lfsr_val < CLR_LIMIT);
                valid_next = 1'b1;
            end
            default: begin
                t_next   = 1'b0;
                clr_next = 1'b0;
            end
        endcase
    end

    // Stimulus registers plus the two-stage valid pipeline: vec_valid marks
    // the vector being driven, cmp_valid marks the cycle its result is due.
    always_ff @(posedge clk) begin
        if (clear) begin
            t_out     <= 1'b0;
            dut_clear <= 1'b1;
            vec_valid <= 1'b0;
            cmp_valid <= 1'b0;
        end else begin
            t_out     <= t_next;
            dut_clear <= clr_next;
            vec_valid <= valid_next;
            cmp_valid <= vec_valid;
        end
    end

    // Pattern counter, counts RUN cycles within the current run.
    always_ff @(posedge clk) begin
        if (clear || start_accept) begin
            pat_cnt <= '0;
        end else if (state == RUN) begin
            pat_cnt <= pat_cnt + 16'd1;
        end
    end

    // Golden T flip-flop, samples the same vector the DUT samples.
    always_ff @(posedge clk) begin
        if (clear) begin
            exp_q <= 1'b0;
        end else if (dut_clear) begin
            exp_q <= 1'b0;
        end else if (t_out) begin
            exp_q <= ~exp_q;
        end
    end

    // Response check: results from the previous run are wiped on start.
    always_ff @(posedge clk) begin
        if (clear || start_accept) begin
            fault_indicator <= 1'b0;
            fail_count      <= '0;
        end else if (cmp_valid && (dut_q != exp_q)) begin
            fault_indicator <= 1'b1;
            fail_count      <= sat_inc(fail_count);
        end
    end

endmodule

// File: tb/tb_tff_bist_gen.sv
// ---------------------------------------------------------------------------
// tb_tff_bist_gen
// Self-checking bench for tff_bist_gen. Two instances: u_a (N=200) and
// u_b (N=300), each wired to a behavioural T flip-flop whose returned q can
// be good, stuck-at-0 or inverted. Expected vectors and run results are
// queued when a run is launched; a monitor compares them as the selected
// instance presents them.
// ---------------------------------------------------------------------------
module tb_tff_bist_gen;

    typedef struct {
        int done_edge;
        int busy_cycles;
        int fail_count;
        int fault;
    } run_result_t;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       q_a = 1'b0;
    logic       q_b = 1'b0;
    int         mode_a = 0;
    int         mode_b = 0;
    bit         sel_b = 1'b0;
    int         cyc = 0;

    logic       dut_q_a, dut_q_b;
    logic       t_a, c_a, busy_a, done_a, fault_a;
    logic       t_b, c_b, busy_b, done_b, fault_b;
    logic [7:0] fc_a, fc_b;

    logic       mon_t, mon_c, mon_busy, mon_done, mon_fault;
    logic [7:0] mon_fc;

    logic [1:0]  vec_q[$];
    run_result_t res_q[$];

    int n_checks = 0;
    int n_pass = 0;

    int  busy_cnt = 0;
    bit  busy_prev = 1'b0;
    bit  done_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural flip-flops under test (mode 0 good, 1 stuck-at-0, 2 inverted).
    always @(posedge clk) begin
        if (c_a) q_a <= 1'b0;
        else if (t_a) q_a <= ~q_a;
    end

    always @(posedge clk) begin
        if (c_b) q_b <= 1'b0;
        else if (t_b) q_b <= ~q_b;
    end

    assign dut_q_a = (mode_a == 0) ? q_a : (mode_a == 1) ? 1'b0 : ~q_a;
    assign dut_q_b = (mode_b == 0) ? q_b : (mode_b == 1) ? 1'b0 : ~q_b;

    assign mon_t     = sel_b ? t_b     : t_a;
    assign mon_c     = sel_b ? c_b     : c_a;
    assign mon_busy  = sel_b ? busy_b  : busy_a;
    assign mon_done  = sel_b ? done_b  : done_a;
    assign mon_fault = sel_b ? fault_b : fault_a;
    assign mon_fc    = sel_b ? fc_b    : fc_a;

    tff_bist_gen #(.LFSR_W(8), .SEED(8'hA5), .N_PATTERNS(200)) u_a (
        .clk             (clk),
        .clear           (clear),
        .start           (start_a),
        .dut_q           (dut_q_a),
        .t_out           (t_a),
        .dut_clear       (c_a),
        .busy            (busy_a),
        .done            (done_a),
        .fault_indicator (fault_a),
        .fail_count      (fc_a)
    );

    tff_bist_gen #(.LFSR_W(8), .SEED(8'hA5), .N_PATTERNS(300)) u_b (
        .clk             (clk),
        .clear           (clear),
        .start           (start_b),
        .dut_q           (dut_q_b),
        .t_out           (t_b),
        .dut_clear       (c_b),
        .busy            (busy_b),
        .done            (done_b),
        .fault_indicator (fault_b),
        .fail_count      (fc_b)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [7:0] lfsrNext(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Queue the expected vectors of one run and work out the mismatch total.
    task automatic expectRun(input int n, input int mode,
                             output int exp_fail, output int exp_fault);
        logic [7:0] hand[8] = '{8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54, 8'hA9, 8'h53, 8'hA7};
        logic [7:0] l = 8'hA5;
        logic [7:0] v;
        logic       t, c;
        logic       q = 1'b0;
        int         bad = 0;
        vec_q.push_back(2'b01);
        if (mode == 2) bad++;
        for (int k = 0; k < n; k++) begin
            v = (k < 8) ? hand[k] : l;
            t = v[0];
            c = (v[7:5] == 3'b000);
            vec_q.push_back({t, c});
            if (c) q = 1'b0;
            else if (t) q = ~q;
            if (mode == 1 && q) bad++;
            if (mode == 2) bad++;
            l = lfsrNext(l);
        end
        vec_q.push_back(2'b00);
        exp_fail  = (bad > 255) ? 255 : bad;
        exp_fault = (bad > 0) ? 1 : 0;
    endtask

    // Launch one run; optional fixed start edge, ignored re-start, or abort.
    task automatic applyStimulus(input bit use_b, input int n, input int mode,
                                 input int start_at, input int restart_at, input int clear_at);
        int ef, eft, s;
        run_result_t r;
        sel_b = use_b;
        if (use_b) mode_b = mode; else mode_a = mode;
        expectRun(n, mode, ef, eft);
        @(negedge clk);
        while (start_at > 0 && cyc < start_at - 1) @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start_a = 1'b0;
        start_b = 1'b0;
        r.done_edge   = (start_at > 0) ? start_at + n + 2 : s + n + 2;
        r.busy_cycles = n + 2;
        r.fail_count  = ef;
        r.fault       = eft;
        res_q.push_back(r);
        if (restart_at > 0) begin
            while (cyc < s + restart_at) @(negedge clk);
            if (use_b) start_b = 1'b1; else start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
        end
        if (clear_at > 0) begin
            while (cyc < s + clear_at) @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            vec_q.delete();
            res_q.delete();
            checkOutput("abort_busy", int'(mon_busy), 0);
            checkOutput("abort_done", int'(mon_done), 0);
            checkOutput("abort_fault", int'(mon_fault), 0);
            checkOutput("abort_fail_count", int'(mon_fc), 0);
            checkOutput("abort_dut_clear", int'(mon_c), 1);
            clear = 1'b0;
        end else begin
            for (int i = 0; i < n + 20; i++) begin
                @(negedge clk);
                if (mon_done) break;
            end
            if (!mon_done) begin
                n_checks++;
                $display("[TB] FAIL done_timeout: done got 0, expected 1 within %0d cycles", n + 20);
            end
            @(negedge clk);
        end
    endtask

    // Monitor: checks each driven vector while busy and the run result when
    // done rises.
    initial begin
        run_result_t r;
        logic [1:0]  ev;
        forever begin
            @(negedge clk);
            if (mon_busy && !busy_prev) busy_cnt = 0;
            if (mon_busy) begin
                busy_cnt++;
                if (vec_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL vector_queue: got a vector while busy, expected none");
                end else begin
                    ev = vec_q.pop_front();
                    checkOutput("t_out", int'(mon_t), int'(ev[1]));
                    checkOutput("dut_clear", int'(mon_c), int'(ev[0]));
                end
            end
            if (mon_done && !done_prev) begin
                if (res_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL result_queue: done rose, no run expected");
                end else begin
                    r = res_q.pop_front();
                    checkOutput("done_edge", cyc, r.done_edge);
                    checkOutput("busy_cycles", busy_cnt, r.busy_cycles);
                    checkOutput("fail_count", int'(mon_fc), r.fail_count);
                    checkOutput("fault_indicator", int'(mon_fault), r.fault);
                    checkOutput("vectors_left", vec_q.size(), 0);
                end
            end
            busy_prev = mon_busy;
            done_prev = mon_done;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] tff_bist_gen bench starting");
        clear = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_t_out", int'(t_a), 0);
        checkOutput("reset_dut_clear", int'(c_a), 1);
        checkOutput("reset_busy", int'(busy_a), 0);
        checkOutput("reset_done", int'(done_a), 0);
        checkOutput("reset_fault", int'(fault_a), 0);
        checkOutput("reset_fail_count", int'(fc_a), 0);
        clear = 1'b0;

        $display("[TB] good TFF, N=200, start at cycle 5");
        applyStimulus(1'b0, 200, 0, 5, 0, 0);
        $display("[TB] good TFF with ignored start in RUN");
        applyStimulus(1'b0, 200, 0, 0, 49, 0);
        $display("[TB] stuck-at-0 TFF, N=200");
        applyStimulus(1'b0, 200, 1, 0, 0, 0);
        $display("[TB] inverted TFF, N=300");
        applyStimulus(1'b1, 300, 2, 0, 0, 0);
        $display("[TB] clear during RUN cycle 100");
        applyStimulus(1'b0, 200, 1, 0, 100, 100);
        $display("[TB] fresh run after clear");
        applyStimulus(1'b0, 200, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
